// File: rtl/sys_feeder.sv
// sys_feeder: streams matrix A rows / B columns from the operand RAM into the 2x2 systolic array edge.
// Optional feature: define FEEDER_STALL_CNT_EN to add the stall_cnt[15:0] RUN-stall counter output.
module sys_feeder #(
  parameter int DW   = 16,
  parameter int AW   = 10,
  parameter int LENW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [LENW-1:0] len,
  input  logic [AW-1:0]   base,
  output logic            ram_ren,
  output logic [AW-1:0]   ram_radr,
  input  logic [4*DW-1:0] ram_rdata,
  input  logic            aff0,
  input  logic            aff1,
  input  logic            bff0,
  input  logic            bff1,
  output logic [DW-1:0]   a_in0,
  output logic [DW-1:0]   a_in1,
  output logic [DW-1:0]   b_in0,
  output logic [DW-1:0]   b_in1,
  output logic            awe0,
  output logic            awe1,
  output logic            bwe0,
  output logic            bwe1,
  output logic            start,
  output logic [LENW-1:0] max_cntr,
`ifdef FEEDER_STALL_CNT_EN
  output logic [15:0]     stall_cnt,
`endif
  output logic            busy,
  output logic            done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_START = 2'd3;

  logic [1:0]      state;
  logic [AW-1:0]   base_q;
  logic [LENW-1:0] k_q;
  logic            rd_valid;   // RAM word for lane 0 arrives this cycle
  logic            lane1_we;
  logic [DW-1:0]   a0_q, b0_q, a1_q, b1_q;

  logic            stall;
  logic            issue;
  logic            last_issue;

  // RAM word layout is {b1, b0, a1, a0}.
  logic [DW-1:0] rd_a0, rd_a1, rd_b0, rd_b1;
  assign rd_a0 = ram_rdata[DW-1:0];
  assign rd_a1 = ram_rdata[2*DW-1:DW];
  assign rd_b0 = ram_rdata[3*DW-1:2*DW];
  assign rd_b1 = ram_rdata[4*DW-1:3*DW];

  // Flags are looked at in the issuing cycle itself, so at most two writes per FIFO are ever in flight.
  assign stall      = aff0 | aff1 | bff0 | bff1;
  assign issue      = (state == S_RUN) && !stall;
  assign last_issue = issue && (k_q == max_cntr - LENW'(1));

  assign ram_ren  = issue;
  assign ram_radr = (state == S_RUN) ? base_q + AW'(k_q) : '0;
  assign start    = (state == S_START);

  // Lane 0 passes returning RAM data straight through; between strobes it shows the last written value.
  // NOTE: every signal gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    a_in0 = a0_q;
    b_in0 = b0_q;
    awe0  = 1'b0;
    bwe0  = 1'b0;
    if (rd_valid) begin
      a_in0 = rd_a0;
      b_in0 = rd_b0;
      awe0  = 1'b1;
      bwe0  = 1'b1;
    end
  end

  assign a_in1 = a1_q;
  assign b_in1 = b1_q;
  assign awe1  = lane1_we;
  assign bwe1  = lane1_we;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      base_q   <= '0;
      k_q      <= '0;
      max_cntr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      lane1_we <= 1'b0;
      a0_q     <= '0;
      b0_q     <= '0;
      a1_q     <= '0;
      b1_q     <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= issue;
      lane1_we <= rd_valid;
      if (rd_valid) begin
        a0_q <= rd_a0;
        b0_q <= rd_b0;
        a1_q <= rd_a1;   // skew register: lane 1 is written one cycle after lane 0
        b1_q <= rd_b1;
      end

      case (state)
        S_IDLE: begin
          if (go) begin
            if (len != '0) begin
              max_cntr <= len;
              base_q   <= base;
              k_q      <= '0;
              busy     <= 1'b1;
              state    <= S_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            k_q <= k_q + LENW'(1);
            if (last_issue) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // With no lane-0 return pending, the final lane-1 write is happening now.
          if (!rd_valid) state <= S_START;
        end
        S_START: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == S_IDLE && go) begin
      stall_cnt <= '0;
    end else if (state == S_RUN && stall && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sys_feeder.sv
// Self-checking bench for sys_feeder: directed vector table, hand sequences and random feeds vs a RAM-level model.
module tb_sys_feeder;
  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int LENW  = 8;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            go = 1'b0;
  logic [LENW-1:0] len = '0;
  logic [AW-1:0]   base = '0;
  logic            ram_ren;
  logic [AW-1:0]   ram_radr;
  logic [4*DW-1:0] ram_rdata;
  logic            aff0 = 1'b0, aff1 = 1'b0, bff0 = 1'b0, bff1 = 1'b0;
  logic [DW-1:0]   a_in0, a_in1, b_in0, b_in1;
  logic            awe0, awe1, bwe0, bwe1;
  logic            start;
  logic [LENW-1:0] max_cntr;
  logic            busy, done;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  sys_feeder #(.DW(DW), .AW(AW), .LENW(LENW)) dut (
    .clk(clk), .rst(rst), .go(go), .len(len), .base(base),
    .ram_ren(ram_ren), .ram_radr(ram_radr), .ram_rdata(ram_rdata),
    .aff0(aff0), .aff1(aff1), .bff0(bff0), .bff1(bff1),
    .a_in0(a_in0), .a_in1(a_in1), .b_in0(b_in0), .b_in1(b_in1),
    .awe0(awe0), .awe1(awe1), .bwe0(bwe0), .bwe1(bwe1),
    .start(start), .max_cntr(max_cntr),
`ifdef FEEDER_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .busy(busy), .done(done)
  );

  // Operand RAM: one-cycle read latency, junk on the bus when not read.
  logic [4*DW-1:0] mem [DEPTH];
  always @(posedge clk) ram_rdata <= ram_ren ? mem[ram_radr] : {$urandom, $urandom};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; int c; } wr_t;
  wr_t l0_q[$];
  wr_t l1_q[$];
  int  adr_q[$], adr_c_q[$], start_q[$], done_q[$], busy_q[$], stall_q[$];
  int  hold_bad = 0, pair_bad = 0, flow_bad = 0;
  logic [DW-1:0] last_a0 = '0, last_b0 = '0, last_a1 = '0, last_b1 = '0;
  logic rst_prev = 1'b0;
  logic [3:0] ff_prev = '0;
  int ff_run[4] = '{0, 0, 0, 0};

  always @(negedge clk) begin : mon
    logic [3:0] ffv;
    logic [3:0] wev;
    if (rst_prev) begin
      last_a0 = '0; last_b0 = '0; last_a1 = '0; last_b1 = '0;
    end
    ffv = {bff1, bff0, aff1, aff0};
    wev = {bwe1, bwe0, awe1, awe0};
    if (awe0 !== bwe0 || awe1 !== bwe1) pair_bad++;
    if (awe0 === 1'b1) begin
      l0_q.push_back('{a_in0, b_in0, cyc});
      last_a0 = a_in0; last_b0 = b_in0;
    end else if (a_in0 !== last_a0 || b_in0 !== last_b0) hold_bad++;
    if (awe1 === 1'b1) begin
      l1_q.push_back('{a_in1, b_in1, cyc});
      last_a1 = a_in1; last_b1 = b_in1;
    end else if (a_in1 !== last_a1 || b_in1 !== last_b1) hold_bad++;
    if (ram_ren === 1'b1) begin
      adr_q.push_back(int'(ram_radr));
      adr_c_q.push_back(cyc);
    end
    if (start === 1'b1) start_q.push_back(cyc);
    if (done === 1'b1)  done_q.push_back(cyc);
    if (busy === 1'b1)  busy_q.push_back(cyc);
    if (|ffv) stall_q.push_back(cyc);
    // A FIFO whose flag stays high may receive at most 2 further writes.
    for (int i = 0; i < 4; i++) begin
      if (!ff_prev[i]) ff_run[i] = 0;
      else if (wev[i] === 1'b1) ff_run[i]++;
      if (ff_run[i] > 2) flow_bad++;
    end
    ff_prev  = ffv;
    rst_prev = rst;
  end

  // ---------------- stimulus helpers ----------------
  int flag_mode = 0;  // 0: quiet, 1: random, 2: bff1 high at relative cycles 3..5
  int feed_c0   = 0;

  task automatic tick();
    int r;
    @(posedge clk);
    #1;
    r = cyc - feed_c0;
    case (flag_mode)
      1: begin
        aff0 = ($urandom_range(5, 0) == 0);
        aff1 = ($urandom_range(5, 0) == 0);
        bff0 = ($urandom_range(5, 0) == 0);
        bff1 = ($urandom_range(5, 0) == 0);
      end
      2: begin
        {aff0, aff1, bff0} = 3'b000;
        bff1 = (r >= 3 && r <= 5);
      end
      default: {aff0, aff1, bff0, bff1} = 4'b0000;
    endcase
  endtask

  task automatic clear_mon();
    l0_q.delete(); l1_q.delete(); adr_q.delete(); adr_c_q.delete();
    start_q.delete(); done_q.delete(); busy_q.delete(); stall_q.delete();
  endtask

  task automatic load_pattern(input int b);
    for (int i = 0; i < DEPTH; i++)
      mem[(b + i) % DEPTH] = {DW'(4*i+3), DW'(4*i+2), DW'(4*i+1), DW'(4*i)};
  endtask

  task automatic run_feed(input int l, input int b, input int extra_go, output int c0);
    clear_mon();
    go = 1'b1; len = LENW'(l); base = AW'(b);
    {aff0, aff1, bff0, bff1} = 4'b0000;
    c0 = cyc; feed_c0 = cyc;
    tick();
    go = 1'b0; len = LENW'($urandom); base = AW'($urandom);
    for (int i = 0; i < 3000 && done_q.size() == 0; i++) begin
      if (extra_go >= 0 && cyc - c0 == extra_go) go = 1'b1;
      tick();
      go = 1'b0;
    end
    check("done_seen", done_q.size() != 0, 1'b1);
    repeat (3) tick();
  endtask

  task automatic check_feed(input string tag, input int l, input int b, input int c0,
                            input bit timed, input int exp_start, input int exp_done);
    logic [4*DW-1:0] w;
    int dbad, abad, tbad, bbad, exp_busy;
    int run_stalls;
    dbad = 0; abad = 0; tbad = 0; bbad = 0;
    check({tag, "/lane0_cnt"}, l0_q.size(), l);
    check({tag, "/lane1_cnt"}, l1_q.size(), l);
    check({tag, "/ren_cnt"}, adr_q.size(), l);
    for (int k = 0; k < l; k++) begin
      w = mem[(b + k) % DEPTH];
      if (k < l0_q.size()) begin
        if (l0_q[k].a !== w[DW-1:0] || l0_q[k].b !== w[3*DW-1:2*DW]) dbad++;
        if (timed && l0_q[k].c != c0 + k + 2) tbad++;
      end
      if (k < l1_q.size()) begin
        if (l1_q[k].a !== w[2*DW-1:DW] || l1_q[k].b !== w[4*DW-1:3*DW]) dbad++;
        if (timed && l1_q[k].c != c0 + k + 3) tbad++;
      end
      if (k < adr_q.size() && adr_q[k] != (b + k) % DEPTH) abad++;
    end
    check({tag, "/data_order_errs"}, dbad, 0);
    check({tag, "/addr_errs"}, abad, 0);
    check({tag, "/start_cnt"}, start_q.size(), (l != 0) ? 1 : 0);
    check({tag, "/done_cnt"}, done_q.size(), 1);
    if (timed || l == 0) begin
      check({tag, "/done_cycle"}, (done_q.size() != 0) ? done_q[0] - c0 : -1, exp_done);
      if (l != 0) begin
        check({tag, "/start_cycle"}, (start_q.size() != 0) ? start_q[0] - c0 : -1, exp_start);
        check({tag, "/strobe_timing_errs"}, tbad, 0);
      end
    end else if (start_q.size() == 1 && done_q.size() == 1) begin
      check({tag, "/start_to_done"}, done_q[0] - start_q[0], 1);
    end
    if (done_q.size() == 1) begin
      foreach (busy_q[i]) if (busy_q[i] <= c0 || busy_q[i] >= done_q[0]) bbad++;
      exp_busy = (l == 0) ? 0 : done_q[0] - c0 - 1;
      check({tag, "/busy_outside"}, bbad, 0);
      check({tag, "/busy_cycles"}, busy_q.size(), exp_busy);
    end
    if (l != 0) check({tag, "/max_cntr"}, max_cntr, l);
    check({tag, "/hold_errs"}, hold_bad, 0);
    check({tag, "/pair_errs"}, pair_bad, 0);
    check({tag, "/flow_errs"}, flow_bad, 0);
    hold_bad = 0; pair_bad = 0; flow_bad = 0;
    // RUN spans from the cycle after go up to the final issue.
    run_stalls = 0;
    if (adr_c_q.size() != 0)
      foreach (stall_q[i]) if (stall_q[i] > c0 && stall_q[i] <= adr_c_q[$]) run_stalls++;
`ifdef FEEDER_STALL_CNT_EN
    if (l != 0) check({tag, "/stall_cnt"}, stall_cnt, run_stalls);
`else
    if (run_stalls < 0) check({tag, "/stall_cycles"}, run_stalls, 0);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/ram_ren"}, ram_ren, 0);
    check({tag, "/ram_radr"}, ram_radr, 0);
    check({tag, "/lane_data"}, {a_in0, a_in1, b_in0, b_in1}, 0);
    check({tag, "/strobes"}, {awe0, awe1, bwe0, bwe1}, 0);
    check({tag, "/start"}, start, 0);
    check({tag, "/max_cntr"}, max_cntr, 0);
    check({tag, "/busy"}, busy, 0);
    check({tag, "/done"}, done, 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct { int len; int base; int extra_go; int exp_start; int exp_done; } vec_t;
  vec_t vecs[6];

  initial begin
    int c0, l, b, pbad;

    vecs[0] = '{4,   'h010, -1,   7,   8};   // basic feed
    vecs[1] = '{1,   'h000, -1,   4,   5};
    vecs[2] = '{0,   'h123, -1,  -1,   1};   // zero length
    vecs[3] = '{4,   'h3FE, -1,   7,   8};   // address wrap
    vecs[4] = '{5,   'h040,  3,   8,   9};   // go while busy
    vecs[5] = '{255, 'h200, -1, 258, 259};

    tick(); tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    hold_bad = 0; pair_bad = 0; flow_bad = 0;
    tick();

    foreach (vecs[v]) begin
      load_pattern(vecs[v].base);
      run_feed(vecs[v].len, vecs[v].base, vecs[v].extra_go, c0);
      check_feed($sformatf("vec%0d", v), vecs[v].len, vecs[v].base, c0, 1'b1,
                 vecs[v].exp_start, vecs[v].exp_done);
      pbad = 0;
      for (int k = 0; k < l0_q.size() && k < l1_q.size(); k++)
        if (l0_q[k].a !== DW'(4*k) || l1_q[k].a !== DW'(4*k+1) ||
            l0_q[k].b !== DW'(4*k+2) || l1_q[k].b !== DW'(4*k+3)) pbad++;
      check($sformatf("vec%0d/pattern_errs", v), pbad, 0);
      if (vecs[v].base == 'h3FE && adr_q.size() == 4)
        check("wrap/third_addr", adr_q[2], 0);
    end

    // Backpressure: bff1 high for 3 cycles right after the second issue.
    load_pattern('h300);
    flag_mode = 2;
    run_feed(6, 'h300, -1, c0);
    check_feed("backpressure", 6, 'h300, c0, 1'b0, 0, 0);
    check("backpressure/done_cycle", (done_q.size() != 0) ? done_q[0] - c0 : -1, 13);
`ifdef FEEDER_STALL_CNT_EN
    check("backpressure/stall_cnt_3", stall_cnt, 3);
`endif
    flag_mode = 0;
    tick();

    // Random feeds against the RAM-content model.
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    flag_mode = 1;
    for (int t = 0; t < 14; t++) begin
      l = (t % 7 == 6) ? 0 : int'($urandom_range(20, 1));
      b = int'($urandom_range(DEPTH - 1, 0));
      run_feed(l, b, -1, c0);
      check_feed($sformatf("rand%0d", t), l, b, c0, 1'b0, l + 3, (l == 0) ? 1 : l + 4);
    end
    flag_mode = 0;
    tick();

    // Reset during RUN with a read in flight, then a fresh feed.
    load_pattern('h080);
    clear_mon();
    go = 1'b1; len = 8'd8; base = 10'h080; feed_c0 = cyc;
    tick();
    go = 1'b0;
    tick(); tick();
    check("midrst/read_in_flight", ram_ren, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    clear_mon();
    repeat (6) tick();
    check("midrst/late_lane0", l0_q.size(), 0);
    check("midrst/late_lane1", l1_q.size(), 0);
    check("midrst/late_start_done", start_q.size() + done_q.size() + busy_q.size(), 0);
    run_feed(3, 'h080, -1, c0);
    check_feed("after_rst", 3, 'h080, c0, 1'b1, 6, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
